// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte_ready edge-detect into a first-word-fall-through FIFO with valid/ready output and sticky overflow; define UART_RX_FIFO_DROP_CNT_EN to add drop_count.
module uart_rx_fifo #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_ready,
    input  logic [7:0]        data_in,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
    output logic [7:0]        drop_count,
`endif
    input  logic              ovf_clr
);
    localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] ZERO  = '0;
    localparam logic [ADDR_W:0] AFULL = (ADDR_W + 1)'(AFULL_LEVEL);
    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wrPtr, rdPtr;
    logic            byteReadyD, push, pop, full, doPush, drop;
    always_comb begin
        push        = byte_ready & ~byteReadyD;
        m_valid     = wrPtr != rdPtr;
        full        = (wrPtr[ADDR_W] != rdPtr[ADDR_W]) && (wrPtr[ADDR_W-1:0] == rdPtr[ADDR_W-1:0]);
        pop         = m_valid & m_ready;
        doPush      = push & (~full | pop);
        drop        = push & full & ~pop;
        m_data      = mem[rdPtr[ADDR_W-1:0]];
        almost_full = count >= AFULL;
    end
    // byteReadyD resets high so a byte_ready already high at release is not pushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byteReadyD <= 1'b1;
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            byteReadyD <= byte_ready;
            wrPtr      <= doPush ? wrPtr + ONE : wrPtr;
            rdPtr      <= pop ? rdPtr + ONE : rdPtr;
            count      <= count + (doPush ? ONE : ZERO) - (pop ? ONE : ZERO);
            overflow   <= drop | (overflow & ~ovf_clr);
        end
    end
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr[ADDR_W-1:0]] <= data_in;
    end
`ifdef UART_RX_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_count <= 8'd0;
        else drop_count <= ovf_clr ? {7'd0, drop} : drop_count + {7'd0, drop & ~&drop_count};
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed stimulus with an expected-byte queue checked by a separate output monitor.
module tb_uart_rx_fifo;
    logic       clk = 0, rst_n = 0, byte_ready = 1, m_ready = 0, ovf_clr = 0;
    logic [7:0] data_in = 8'h41, m_data;
    logic       m_valid, almost_full, overflow;
    logic [4:0] count;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_count;
`endif
    int         checks = 0, errors = 0, pushes = 0, pops = 0;
    bit         cntChk = 0, randDone = 0;
    logic [7:0] expQ [$];

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .byte_ready(byte_ready), .data_in(data_in),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .count(count),
        .almost_full(almost_full), .overflow(overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pushByte(input logic [7:0] d, input bit drop, input bit clr, input bit rdy);
        data_in = d;
        byte_ready = 1;
        ovf_clr = clr;
        if (rdy) m_ready = 1;
        if (!drop) expQ.push_back(d);
        tick;
        if (!drop) pushes++;
        byte_ready = 0;
        ovf_clr = 0;
        if (rdy) m_ready = 0;
        tick;
    endtask

    task automatic drain;
        m_ready = 1;
        for (int i = 0; i < 100 && count != 0; i++) tick;
        check("drain_count", 16'(count), 16'd0);
        check("drain_queue_empty", 16'(expQ.size()), 16'd0);
        m_ready = 0;
    endtask

    // compare at the falling edge whatever the next rising edge will pop
    always @(negedge clk) begin
        if (rst_n) begin
            if (cntChk) check("count_model", 16'(count), 16'(pushes - pops));
            if (m_valid && m_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop got %0h expected none", m_data);
                end else check("m_data", 16'(m_data), 16'(expQ.pop_front()));
                pops++;
            end
        end
    end

    initial begin
        #12 rst_n = 1;
        tick;
        check("rst_m_valid", 16'(m_valid), 16'd0);
        check("rst_overflow", 16'(overflow), 16'd0);
        check("rst_almost_full", 16'(almost_full), 16'd0);
        tick;
        tick;
        check("held_high_count", 16'(count), 16'd0);
        check("held_high_m_valid", 16'(m_valid), 16'd0);
        cntChk = 1;
        byte_ready = 0;
        tick;
        data_in = 8'h41;
        byte_ready = 1;
        expQ.push_back(8'h41);
        tick;
        pushes++;
        check("lat_m_valid", 16'(m_valid), 16'd1);
        check("lat_m_data", 16'(m_data), 16'h41);
        check("lat_count", 16'(count), 16'd1);
        tick;
        check("no_repush", 16'(count), 16'd1);
        byte_ready = 0;
        tick;
        drain;

        for (int i = 1; i <= 5; i++) pushByte(8'(i), 0, 0, 0);
        check("five_count", 16'(count), 16'd5);
        check("five_head", 16'(m_data), 16'h01);
        m_ready = 1;
        for (int i = 0; i < 4; i++) tick;
        check("five_valid_before_last", 16'(m_valid), 16'd1);
        tick;
        check("five_valid_fall", 16'(m_valid), 16'd0);
        check("five_count_zero", 16'(count), 16'd0);
        m_ready = 0;

        for (int i = 0; i < 16; i++) begin
            pushByte(8'h10 + 8'(i), 0, 0, 0);
            check("afull_level", 16'(almost_full), (i + 1 >= 14) ? 16'd1 : 16'd0);
        end
        check("full_count", 16'(count), 16'd16);
        check("full_no_ovf", 16'(overflow), 16'd0);
        pushByte(8'hEE, 1, 0, 0);
        check("drop_overflow", 16'(overflow), 16'd1);
        check("drop_count_unchanged", 16'(count), 16'd16);
        check("drop_head", 16'(m_data), 16'h10);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_count_1", 16'(drop_count), 16'd1);
`endif
        ovf_clr = 1;
        tick;
        ovf_clr = 0;
        check("ovf_cleared", 16'(overflow), 16'd0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_count_cleared", 16'(drop_count), 16'd0);
`endif
        pushByte(8'hEF, 1, 1, 0);
        check("set_wins_clear", 16'(overflow), 16'd1);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        check("drop_with_clear", 16'(drop_count), 16'd1);
`endif
        ovf_clr = 1;
        tick;
        ovf_clr = 0;
        check("ovf_cleared_2", 16'(overflow), 16'd0);
        pushByte(8'h77, 0, 0, 1);
        check("full_pushpop_count", 16'(count), 16'd16);
        check("full_pushpop_ovf", 16'(overflow), 16'd0);
        drain;
        check("drained_afull", 16'(almost_full), 16'd0);

        pushByte(8'hA1, 0, 0, 0);
        pushByte(8'hA2, 0, 0, 0);
        cntChk = 0;
        data_in = 8'h99;
        byte_ready = 1;
        rst_n = 0;
        #1;
        check("async_rst_m_valid", 16'(m_valid), 16'd0);
        check("async_rst_count", 16'(count), 16'd0);
        expQ.delete();
        pushes = 0;
        pops = 0;
        tick;
        rst_n = 1;
        tick;
        tick;
        check("rerst_no_push", 16'(count), 16'd0);
        check("rerst_m_valid", 16'(m_valid), 16'd0);
        byte_ready = 0;
        tick;
        cntChk = 1;

        fork
            begin
                for (int i = 0; i < 40; i++) pushByte(8'h80 + 8'(i * 3), 0, 0, 0);
                randDone = 1;
            end
            begin
                for (int k = 0; !randDone; k++) begin
                    m_ready = k[0] | ($urandom_range(0, 1) == 1);
                    tick;
                end
            end
        join
        check("stream_no_ovf", 16'(overflow), 16'd0);
        drain;
        check("stream_pops", 16'(pops), 16'd40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer placed directly downstream of the UART receiver.
- Turns the receiver's level-style byte-ready flag and parallel byte into single push events and stores the bytes in a synchronous FIFO.
- Presents the bytes to the consumer over a valid/ready stream. Flags overflow when the consumer falls behind the line rate.

Parameters:
- DEPTH, 16: FIFO entries. Must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH): pointer index width. Derived; do not override.
- AFULL_LEVEL, DEPTH-2: fill level at or above which almost_full asserts.

Ports:
- clk  input  1  system clock. The block runs on one clock.
- rst_n  input  1  reset, asynchronous and active-low.
- byte_ready  input  1  receiver byte-ready flag. Level signal: rises when a byte completes and stays high until the next start bit.
- data_in  input  8  receiver byte. Stable whenever byte_ready is high.
- m_data  output  8  head byte of the FIFO (first-word fall-through).
- m_valid  output  1  FIFO not empty.
- m_ready  input  1  consumer accepts the head byte.
- count  output  ADDR_W+1  current fill level, 0..DEPTH.
- almost_full  output  1  count >= AFULL_LEVEL.
- overflow  output  1  sticky flag: a byte was dropped.
- ovf_clr  input  1  single-cycle clear of overflow.

Behaviour:
- Reset (async assert, sync release):
  - write pointer, read pointer and count = 0.
  - m_valid = 0, almost_full = 0 (AFULL_LEVEL >= 1), overflow = 0.
  - byte_ready_d = 1. This suppresses a spurious push when byte_ready is high or X coming out of reset.
  - m_data is don't-care while m_valid = 0. Memory contents are not reset.
- Edge detect:
  - push = byte_ready & ~byte_ready_d, registered every cycle.
  - Exactly one push per byte. A byte_ready held high never repushes.
- Push:
  - Occurs on the same clock edge where push is seen. data_in is written to mem[wr_ptr], and wr_ptr and count update at that edge.
  - m_valid rises the cycle after the push edge. Latency from byte_ready rise to m_valid is 1 clock.
- Pop:
  - pop = m_valid & m_ready. On that edge rd_ptr advances and count decrements.
  - m_data shows the next entry the following cycle.
  - m_data and m_valid must not change while m_valid = 1 and m_ready = 0, except that a push may occur without altering the head.
- Pointers:
  - ADDR_W+1 bits each, wrapping naturally. Full and empty are derived from the pointer MSB compare.
  - count is a registered value and must always equal wr_ptr - rd_ptr.
- Simultaneous push and pop:
  - Both occur. count is unchanged.
  - Legal when full, because the pop frees the slot and no overflow occurs.
  - When empty, pop is impossible (m_valid = 0). No combinational bypass: the pushed byte appears next cycle.
- Overflow:
  - Push while full without a same-cycle pop: the byte is discarded, memory and pointers are unchanged, and overflow is set.
  - overflow holds until an ovf_clr cycle. If set and clear coincide, set wins.
- almost_full is combinational from registered count; no extra latency.
- Reset mid-operation:
  - All content is discarded, outputs take their reset values, and byte_ready_d = 1.
  - A byte whose byte_ready is already high at release is not pushed.

Optional Feature:
- UART_RX_FIFO_DROP_CNT_EN defined:
  - Adds output drop_count [7:0], reset 0.
  - Increments on every discarded byte and saturates at 255.
  - Cleared to 0 by ovf_clr. If a drop coincides with ovf_clr, the result is 1.
- Not defined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release with byte_ready held high, then 0x41 presented -> no push, count = 0, m_valid = 0; next rise of byte_ready with data_in = 0x41 -> m_valid = 1 one clock later, m_data = 0x41, count = 1.
- Push 0x01..0x05 with m_ready = 0, then m_ready = 1 -> pops 0x01,0x02,0x03,0x04,0x05 in order on consecutive cycles; m_valid falls after 0x05; count returns to 0.
- DEPTH = 16: push 16 bytes 0x10..0x1F -> count = 16, almost_full = 1 from count = 14; 17th push 0xEE -> dropped, overflow = 1, drop_count = 1 if enabled; drain yields 0x10..0x1F only.
- Full FIFO, push 0x77 in the same cycle as m_ready = 1 -> count stays 16, overflow stays 0, 0x77 emerges last after draining.
- overflow = 1, pulse ovf_clr -> overflow = 0 next cycle; ovf_clr coincident with a drop -> overflow = 1 (drop_count = 1).
- Push 40 bytes through 16 entries with random m_ready -> output sequence identical to input, count always = pushes - pops, no overflow while consumer keeps up.
